// File: rtl/counter_mod_if.sv
// Bus bundle for counter_mod: control inputs and count/status outputs.
// clk and rst stay as plain ports on the counter itself.
interface counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, clr, load, load_val, up, ovf_clr,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, clr, load, load_val, up, ovf_clr,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/counter_mod.sv
// Up/down modulo counter with clear, load, wrap/saturate, tc, wrap pulse and sticky ovf.
// Define COUNTER_PRESCALE_EN to step only once every PRESCALE enabled cycles.
module counter_mod #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0,
    parameter int               PRESCALE = 4
) (
    input  logic         clk,
    input  logic         rst,
    counter_mod_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 2) begin : g_param_check
        $error("counter_mod: WIDTH must be 1..32 and PRESCALE at least 2");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             tc;
    logic             step_tick;
    logic             step;

    // Boundary is judged on the current count, so the add/sub never has to carry out.
    assign tc = bus.up ? (count_q == MAX_VAL) : (count_q == '0);

`ifdef COUNTER_PRESCALE_EN
    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign step_tick = bus.en && (pre_q == PRE_W'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q;
        if (bus.clr || bus.load) begin
            pre_d = '0;
        end else if (bus.en) begin
            pre_d = step_tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step_tick = bus.en;
`endif

    assign step = step_tick && !bus.clr && !bus.load;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q && !bus.ovf_clr;

        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (step) begin
            if (tc) begin
                // Boundary step: the set of ovf overrides a simultaneous ovf_clr.
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (!SATURATE) begin
                    count_d = bus.up ? '0 : MAX_VAL;
                end
            end else begin
                count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod (WIDTH=4, MAX_VAL=9): vector table plus corner sequences.
module tb_counter_mod;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    counter_mod_if #(.WIDTH(4)) bus   ();
    counter_mod_if #(.WIDTH(4)) bus_s ();

    counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .PRESCALE(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, clr, load, up, ovf_clr;
        logic [3:0] load_val;
        logic [3:0] count;
        logic       tc, wrap, ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void push_vec(input logic en, input logic clr, input logic load,
                                     input logic [3:0] lv, input logic up, input logic oc,
                                     input logic [3:0] c, input logic t, input logic w,
                                     input logic o);
        vec_t v;
        v.en = en; v.clr = clr; v.load = load; v.load_val = lv; v.up = up; v.ovf_clr = oc;
        v.count = c; v.tc = t; v.wrap = w; v.ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main();
        bus.en = 0; bus.clr = 0; bus.load = 0; bus.load_val = 0; bus.up = 1; bus.ovf_clr = 0;
    endtask

    initial begin
        // Up count 0..9 then wrap to 0
        for (int k = 1; k <= 9; k++) push_vec(1,0,0,0,1,0, 4'(k), (k == 9), 0, 0);
        push_vec(1,0,0, 0,1,0, 0,0,1,1);
        push_vec(1,0,0, 0,1,0, 1,0,0,1);
        // Down count through the bottom, then clamped load
        push_vec(1,0,1, 2,1,0, 2,0,0,1);
        push_vec(1,0,0, 0,0,0, 1,0,0,1);
        push_vec(1,0,0, 0,0,0, 0,1,0,1);
        push_vec(1,0,0, 0,0,0, 9,0,1,1);
        push_vec(1,0,0, 0,0,0, 8,0,0,1);
        push_vec(0,0,1,15,0,0, 9,0,0,1);
        push_vec(0,0,0, 0,1,0, 9,1,0,1);
        // Priority and ovf handling
        push_vec(0,0,1, 5,1,0, 5,0,0,1);
        push_vec(1,1,1, 7,1,0, 0,0,0,1);
        push_vec(0,0,0, 0,1,1, 0,0,0,0);
        push_vec(0,0,1, 9,1,0, 9,1,0,0);
        push_vec(1,0,0, 0,1,1, 0,0,1,1);
        push_vec(0,0,0, 0,1,1, 0,0,0,0);
        // Enable gating
        push_vec(0,0,1, 3,1,0, 3,0,0,0);
        push_vec(1,0,0, 0,1,0, 4,0,0,0);
        push_vec(0,0,0, 0,1,0, 4,0,0,0);
        push_vec(1,0,0, 0,1,0, 5,0,0,0);
        push_vec(0,0,0, 0,1,0, 5,0,0,0);
        // Load beats a boundary step: no wrap, no ovf
        push_vec(0,0,1, 9,1,0, 9,1,0,0);
        push_vec(1,0,1, 4,1,0, 4,0,0,0);

        idle_main();
        bus_s.en = 0; bus_s.clr = 0; bus_s.load = 0; bus_s.load_val = 0;
        bus_s.up = 1; bus_s.ovf_clr = 0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_count", bus.count, 0);
        check("rst_wrap",  bus.wrap, 0);
        check("rst_ovf",   bus.ovf, 0);
        check("rst_sat_count", bus_s.count, 0);

        // Asynchronous reset in the middle of counting
        rst = 1'b1;
        bus.en = 1;
        repeat (5) tick();
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_count", bus.count, 0);
        check("async_rst_wrap",  bus.wrap, 0);
        check("async_rst_ovf",   bus.ovf, 0);
        bus.en = 0;
        #10;
        rst = 1'b1;
        tick();
        check("post_rst_count", bus.count, 0);

`ifndef COUNTER_PRESCALE_EN
        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.clr = vecs[i].clr; bus.load = vecs[i].load;
            bus.load_val = vecs[i].load_val; bus.up = vecs[i].up; bus.ovf_clr = vecs[i].ovf_clr;
            tick();
            check($sformatf("vec%0d_count", i), bus.count, vecs[i].count);
            check($sformatf("vec%0d_tc", i),    bus.tc,    vecs[i].tc);
            check($sformatf("vec%0d_wrap", i),  bus.wrap,  vecs[i].wrap);
            check($sformatf("vec%0d_ovf", i),   bus.ovf,   vecs[i].ovf);
        end
        idle_main();

        // Saturating counter: hold at 9, wrap pulses on each boundary step
        begin
            logic [3:0] sat_cnt[5];
            logic       sat_wrp[5];
            sat_cnt = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
            sat_wrp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            bus_s.load = 1; bus_s.load_val = 7; bus_s.up = 1;
            tick();
            check("sat_load", bus_s.count, 7);
            bus_s.load = 0; bus_s.en = 1;
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("sat_up%0d_count", k), bus_s.count, sat_cnt[k]);
                check($sformatf("sat_up%0d_wrap", k),  bus_s.wrap,  sat_wrp[k]);
            end
            bus_s.up = 0;
            tick();
            check("sat_down_count", bus_s.count, 8);
            check("sat_down_wrap",  bus_s.wrap, 0);
            check("sat_ovf",        bus_s.ovf, 1);
            bus_s.en = 0; bus_s.load = 1; bus_s.load_val = 1;
            tick();
            bus_s.load = 0; bus_s.en = 1;
            tick();
            check("sat_bot0_count", bus_s.count, 0);
            check("sat_bot0_wrap",  bus_s.wrap, 0);
            tick();
            check("sat_bot1_count", bus_s.count, 0);
            check("sat_bot1_wrap",  bus_s.wrap, 1);
            bus_s.en = 0;
        end
`else
        // Prescaled stepping: one step every 4 enabled cycles
        bus.en = 1; bus.up = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("pre_cyc%0d", k), bus.count, k / 4);
        end
        bus.en = 0; bus.clr = 1;
        tick();
        bus.clr = 0; bus.en = 1;
        begin
            logic [3:0] pre_exp[10];
            pre_exp = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
            for (int k = 1; k <= 10; k++) begin
                bus.load = (k == 6);
                bus.load_val = 5;
                tick();
                check($sformatf("pre_load_cyc%0d", k), bus.count, pre_exp[k-1]);
            end
        end
        idle_main();
`endif

        // tc follows up between edges, independent of en
        bus.load = 1; bus.load_val = 0;
        tick();
        bus.load = 0;
        bus.up = 1;
        #1;
        check("tc_zero_up", bus.tc, 0);
        bus.up = 0;
        #1;
        check("tc_zero_down", bus.tc, 1);
        bus.load = 1; bus.load_val = 9;
        tick();
        bus.load = 0;
        bus.up = 1;
        #1;
        check("tc_max_up", bus.tc, 1);
        bus.up = 0;
        #1;
        check("tc_max_down", bus.tc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
